// File: rtl/pipelined_adder_pkg.sv
// Shared constants for the pipelined add/subtract unit: default widths, mode encodings and
// saturation bounds used when PIPELINED_ADDER_SAT_EN is defined.
package pipelined_adder_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH  = 32;
  localparam int unsigned DEFAULT_CHUNK_WIDTH = 8;

  // Encodings for the sub input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Saturation helpers return a wide value; callers keep the low `width` bits.
  localparam int unsigned SAT_FN_WIDTH = 128;

  // Largest signed value of the given width: 0x7F..F.
  function automatic logic [SAT_FN_WIDTH-1:0] sat_max(input int unsigned width);
    logic [SAT_FN_WIDTH-1:0] one;
    one = SAT_FN_WIDTH'(1);
    return (one << (width - 1)) - one;
  endfunction

  // Smallest signed value of the given width: 0x80..0.
  function automatic logic [SAT_FN_WIDTH-1:0] sat_min(input int unsigned width);
    logic [SAT_FN_WIDTH-1:0] one;
    one = SAT_FN_WIDTH'(1);
    return one << (width - 1);
  endfunction

endpackage

// File: rtl/chunk_adder_stage.sv
// One combinational ripple slice of the pipelined adder: {c_out, sum} = a + b + c_in.
module chunk_adder_stage #(
  parameter int unsigned CHUNK_WIDTH = 8
) (
  input  logic [CHUNK_WIDTH-1:0] a,
  input  logic [CHUNK_WIDTH-1:0] b,
  input  logic                   c_in,
  output logic [CHUNK_WIDTH-1:0] sum,
  output logic                   c_out
);

  // Widen by one bit so the carry-out falls out of the addition.
  always_comb begin
    {c_out, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK_WIDTH{1'b0}}, c_in};
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit. A DATA_WIDTH-bit ripple add is cut into CHUNK_WIDTH slices, one
// slice per register stage, under a single global stall (adv) driven by the output handshake.
// Each stage register carries a mixed word: finished sum chunks below, untouched A chunks above,
// plus the remaining B' operand, the running carry and the operand sign bits.
// Optional build macro PIPELINED_ADDER_SAT_EN: saturate on signed overflow and sign-extend the
// result into its top bit.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned CHUNK_WIDTH = DEFAULT_CHUNK_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data1,
  input  logic [DATA_WIDTH-1:0] data2,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   result,
  output logic                  overflow
);

  localparam int unsigned STAGES = DATA_WIDTH / CHUNK_WIDTH;
  localparam int unsigned LAST   = STAGES - 1;

  logic                  valid_q [STAGES];
  logic                  valid_d [STAGES];
  logic                  carry_q [STAGES];
  logic                  carry_d [STAGES];
  logic [DATA_WIDTH-1:0] acc_q   [STAGES];
  logic [DATA_WIDTH-1:0] acc_d   [STAGES];
  logic [DATA_WIDTH-1:0] bm_q    [STAGES];
  logic [DATA_WIDTH-1:0] bm_d    [STAGES];
  logic                  a_msb_q [STAGES];
  logic                  a_msb_d [STAGES];
  logic                  b_msb_q [STAGES];
  logic                  b_msb_d [STAGES];
  logic                  overflow_q;
  logic                  overflow_d;

  logic                  adv;
  logic [DATA_WIDTH-1:0] b_mod;

  // Whole pipe moves together; a stalled output freezes every stage.
  assign adv      = !valid_q[LAST] || out_ready;
  assign in_ready = adv;
  assign b_mod    = (sub == OP_SUB) ? ~data2 : data2;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [DATA_WIDTH-1:0]  acc_in;
    logic [DATA_WIDTH-1:0]  bm_in;
    logic                   carry_in;
    logic                   a_msb_in;
    logic                   b_msb_in;
    logic                   valid_in;
    logic [CHUNK_WIDTH-1:0] chunk_sum;
    logic                   chunk_cout;
    logic [DATA_WIDTH-1:0]  acc_next;

    if (k == 0) begin : g_src_port
      assign acc_in   = data1;
      assign bm_in    = b_mod;
      assign carry_in = sub;  // +1 completes the two's-complement negate of B
      assign a_msb_in = data1[DATA_WIDTH-1];
      assign b_msb_in = b_mod[DATA_WIDTH-1];
      assign valid_in = in_valid;
    end else begin : g_src_stage
      assign acc_in   = acc_q[k-1];
      assign bm_in    = bm_q[k-1];
      assign carry_in = carry_q[k-1];
      assign a_msb_in = a_msb_q[k-1];
      assign b_msb_in = b_msb_q[k-1];
      assign valid_in = valid_q[k-1];
    end

    chunk_adder_stage #(
      .CHUNK_WIDTH(CHUNK_WIDTH)
    ) u_chunk (
      .a    (acc_in[k*CHUNK_WIDTH +: CHUNK_WIDTH]),
      .b    (bm_in[k*CHUNK_WIDTH +: CHUNK_WIDTH]),
      .c_in (carry_in),
      .sum  (chunk_sum),
      .c_out(chunk_cout)
    );

    // Replace A's chunk k with its sum; lower chunks are already sums, upper still A.
    always_comb begin
      acc_next = acc_in;
      acc_next[k*CHUNK_WIDTH +: CHUNK_WIDTH] = chunk_sum;
    end

    assign bm_d[k]    = bm_in;
    assign a_msb_d[k] = a_msb_in;
    assign b_msb_d[k] = b_msb_in;
    assign valid_d[k] = valid_in;

    if (k == LAST) begin : g_last
      logic ovf;
      assign ovf        = (a_msb_in == b_msb_in) && (acc_next[DATA_WIDTH-1] != a_msb_in);
      assign overflow_d = ovf;
`ifdef PIPELINED_ADDER_SAT_EN
      logic [SAT_FN_WIDTH-1:0] max_w;
      logic [SAT_FN_WIDTH-1:0] min_w;
      logic [DATA_WIDTH-1:0]   sat_val;
      logic [DATA_WIDTH-1:0]   final_sum;
      assign max_w     = sat_max(DATA_WIDTH);
      assign min_w     = sat_min(DATA_WIDTH);
      assign sat_val   = a_msb_in ? min_w[DATA_WIDTH-1:0] : max_w[DATA_WIDTH-1:0];
      assign final_sum = ovf ? sat_val : acc_next;
      assign acc_d[k]   = final_sum;
      assign carry_d[k] = final_sum[DATA_WIDTH-1];
`else
      assign acc_d[k]   = acc_next;
      assign carry_d[k] = chunk_cout;
`endif
    end else begin : g_mid
      assign acc_d[k]   = acc_next;
      assign carry_d[k] = chunk_cout;
    end
  end

  // Stage registers: clear on reset, otherwise shift by one stage whenever adv is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        acc_q[k]   <= '0;
        bm_q[k]    <= '0;
        a_msb_q[k] <= 1'b0;
        b_msb_q[k] <= 1'b0;
      end
      overflow_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        carry_q[k] <= carry_d[k];
        acc_q[k]   <= acc_d[k];
        bm_q[k]    <= bm_d[k];
        a_msb_q[k] <= a_msb_d[k];
        b_msb_q[k] <= b_msb_d[k];
      end
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = valid_q[LAST];
  assign result    = {carry_q[LAST], acc_q[LAST]};
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (32-bit, 8-bit chunks, latency 4).
module tb_pipelined_adder;

  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 8;
  localparam int unsigned LAT = DW / CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] data1;
  logic [DW-1:0] data2;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [DW:0]   result;
  logic          overflow;

  logic dir_ready;
  logic rand_mode;
  logic rand_bit;

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;

  typedef struct packed {
    logic [DW:0] res;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign out_ready = rand_mode ? rand_bit : dir_ready;

  pipelined_adder #(
    .DATA_WIDTH (DW),
    .CHUNK_WIDTH(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data1    (data1),
    .data2    (data2),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: exact signed/unsigned arithmetic on wide integers.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic s);
    exp_t        e;
    longint      sa;
    longint      sb;
    longint      exact;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] ex_bits;
    logic [DW-1:0] low;
    logic        carry;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    ua    = {32'b0, a};
    ub    = {32'b0, b};
    exact = s ? (sa - sb) : (sa + sb);
    ex_bits = exact;
    low   = ex_bits[DW-1:0];
    carry = s ? (a >= b) : ((ua + ub) > 64'hFFFF_FFFF);
    e.ovf = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
`ifdef PIPELINED_ADDER_SAT_EN
    if (e.ovf) low = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    e.res = {low[DW-1], low};
`else
    e.res = {carry, low};
`endif
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    rand_bit = 1'($urandom_range(0, 1));
  end

  // Scoreboard: whatever sits at the output must match the oldest outstanding transaction.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          check("sb_result", 64'(result), 64'(exp_q[0].res));
          check("sb_overflow", 64'(overflow), 64'(exp_q[0].ovf));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(data1, data2, sub));
    end
  end

  // Present one operand set and return 1 ns after the edge that accepted it.
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s);
    int budget;
    budget   = 2000;
    in_valid = 1'b1;
    data1    = a;
    data2    = b;
    sub      = s;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      budget--;
      if (budget == 0) begin
        check("send_timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic s, input logic [DW:0] exp_res, input logic exp_ovf);
    send(a, b, s);
    for (int i = 0; i < LAT - 1; i++) begin
      @(negedge clk);
      check({tag, "_early"}, 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_result"}, 64'(result), 64'(exp_res));
    check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int budget;
    budget = 5000;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int out_base;
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    logic [DW-1:0] corner [4];
    corner[0] = 32'h0000_0000;
    corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h7FFF_FFFF;
    corner[3] = 32'h8000_0000;

    rst       = 1'b1;
    in_valid  = 1'b0;
    data1     = '0;
    data2     = '0;
    sub       = 1'b0;
    dir_ready = 1'b1;
    rand_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

`ifdef PIPELINED_ADDER_SAT_EN
    run_one("carry", 32'hFFFF_FFFF, 32'h1, 1'b0, 33'h0_0000_0000, 1'b0);
    run_one("sovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 33'h0_7FFF_FFFF, 1'b1);
    run_one("borrow", 32'd5, 32'd7, 1'b1, 33'h1_FFFF_FFFE, 1'b0);
    run_one("noborrow", 32'd7, 32'd5, 1'b1, 33'h0_0000_0002, 1'b0);
    run_one("negovf", 32'h8000_0000, 32'h1, 1'b1, 33'h1_8000_0000, 1'b1);
`else
    run_one("carry", 32'hFFFF_FFFF, 32'h1, 1'b0, 33'h1_0000_0000, 1'b0);
    run_one("sovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 33'h0_8000_0000, 1'b1);
    run_one("borrow", 32'd5, 32'd7, 1'b1, 33'h0_FFFF_FFFE, 1'b0);
    run_one("noborrow", 32'd7, 32'd5, 1'b1, 33'h1_0000_0002, 1'b0);
    run_one("negovf", 32'h8000_0000, 32'h1, 1'b1, 33'h1_7FFF_FFFF, 1'b1);
`endif

    // Back-pressure: stall the consumer as soon as the first of 8 results shows up.
    out_base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send(DW'(i), 32'h100, 1'b0);
      end
      begin
        int budget;
        budget = 100;
        do begin
          @(posedge clk);
          #1;
          budget--;
        end while (!out_valid && budget > 0);
        dir_ready = 1'b0;
        #1;
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_first", 64'(result), 64'h100);
        repeat (5) begin
          @(negedge clk);
          check("bp_hold_valid", 64'(out_valid), 64'd1);
          check("bp_hold_result", 64'(result), 64'h100);
        end
        @(posedge clk);
        #1;
        dir_ready = 1'b1;
      end
    join
    wait_drain("bp_drain");
    check("bp_count", 64'(n_out - out_base), 64'd8);

    // Reset with three transactions in flight.
    for (int i = 0; i < 3; i++) send(32'h1000 + DW'(i), 32'h22, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_result", 64'(result), 64'd0);
    check("mid_rst_ovf", 64'(overflow), 64'd0);
    repeat (8) begin
      @(negedge clk);
      check("mid_rst_quiet", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    // Random regression with random consumer stalls.
    rand_mode = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      send(ra, rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_mode = 1'b0;
    dir_ready = 1'b1;
    wait_drain("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined add/subtract unit. It splits a DATA_WIDTH-bit ripple-carry add into CHUNK_WIDTH-bit slices, one slice per pipeline stage, so wide operands meet timing.
- Valid/ready handshakes on input and output.
- Sits between operand producers and result consumers in the datapath, replacing single-cycle combinational adders where width or clock rate demands it.

Parameters:
- DATA_WIDTH, 32, operand width in bits. Must be a multiple of CHUNK_WIDTH.
- CHUNK_WIDTH, 8, bits added per pipeline stage.
- STAGES, DATA_WIDTH/CHUNK_WIDTH, derived (localparam); also the latency in cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and mode are valid this cycle.
- in_ready  out  1  unit accepts operands this cycle.
- data1  in  DATA_WIDTH  operand A.
- data2  in  DATA_WIDTH  operand B.
- sub  in  1  0 = A+B; 1 = A-B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  DATA_WIDTH+1  {carry_out, sum}.
- overflow  out  1  two's-complement signed overflow flag.

Behaviour:
- Reset: synchronous, active-high, on clk.
  - All stage valid bits, out_valid, result and overflow clear to 0.
  - in_ready is 1 in the first cycle after rst deasserts.
  - Reset mid-operation discards all in-flight transactions with no partial output.
- Handshake:
  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
  - in_valid and operands may change freely while in_ready=0. No combinational path from in_valid to in_ready.
- Pipeline control: global enable adv = !out_valid || out_ready; in_ready = adv.
  - When adv=0, every stage holds and no new operand is captured.
  - Bubbles are not collapsed.
- Subtraction: B' = sub ? ~data2 : data2; carry-in to chunk 0 = sub. The sub bit travels with the transaction.
- Stage k (k = 0..STAGES-1):
  - Registers chunk k of the sum: A[k] + B'[k] + carry from stage k-1.
  - Registers the carry-out.
  - Forwards the lower sum chunks already computed and the unconsumed upper operand chunks (skew/deskew registers).
  - Stage valid bit shifts with adv.
- Latency: a transaction accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES register stages. The last stage is the output register.
- Throughput: one transaction per cycle while out_ready=1.
- result[DATA_WIDTH-1:0] is the modulo-2^DATA_WIDTH sum/difference.
- result[DATA_WIDTH] is the final carry-out. For subtract it is 1 when there is no borrow (A >= B unsigned).
- overflow = (A_msb == B'_msb) && (sum_msb != A_msb), computed in the last stage.
- Outputs hold stable while out_valid && !out_ready.
- STAGES == 1: degenerates to a single registered adder with the same handshake.

Optional Feature:
- Macro PIPELINED_ADDER_SAT_EN.
- When defined:
  - On overflow, result[DATA_WIDTH-1:0] saturates to 0x7F..F when A is non-negative, or 0x80..0 when A is negative.
  - result[DATA_WIDTH] equals result[DATA_WIDTH-1].
  - overflow still reports the condition.
- When undefined: wrap-around result as above, with no added logic.

Decomposition:
- Package pipelined_adder_pkg:
  - default DATA_WIDTH/CHUNK_WIDTH constants;
  - mode encodings OP_ADD=1'b0, OP_SUB=1'b1;
  - saturation constant functions (max/min for a given width).
- Sub-module chunk_adder_stage:
  - one combinational CHUNK_WIDTH ripple slice (a, b, c_in -> sum, c_out);
  - instantiated once per stage by a generate loop; all registers stay in the top module.

Test Plan (DATA_WIDTH=32, CHUNK_WIDTH=8, latency 4):
- Add with full carry: rst for 2 cycles, then add 0xFFFFFFFF + 0x00000001, out_ready=1 -> out_valid 4 cycles later; result=0x1_00000000, overflow=0.
- Signed overflow: add 0x7FFFFFFF + 0x00000001 -> result=0x0_80000000, overflow=1. With PIPELINED_ADDER_SAT_EN -> result=0x0_7FFFFFFF, overflow=1.
- Subtract with borrow: 5 - 7 -> result=0x0_FFFFFFFE, overflow=0. Then 7 - 5 -> result=0x1_00000002.
- Back-pressure: 8 back-to-back adds i + 0x100 (i = 0..7), with out_ready=0 from the cycle the first result is valid -> in_ready drops 0 in that cycle, first result held stable. Release out_ready -> all 8 results appear in order, none lost or duplicated.
- Reset mid-flight: 3 transactions in flight, assert rst for 1 cycle -> out_valid=0 and result=0 the following cycle; no stale result ever appears.
- Random regression: 10k random operands/modes with random out_ready -> match a reference model of A±B (and saturation when PIPELINED_ADDER_SAT_EN is defined).
